// File: rtl/bsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bsub_pkg
// Purpose  : Shared constants and state encoding for the block-serial
//            borrow-skip subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package bsub_pkg;

    localparam int BLK_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bsub_block.sv
`default_nettype none
// ============================================================================
// Module   : bsub_block
// Purpose  : Combinational 4-bit borrow-skip subtract block (d = a - b - bin).
// Revision : 1.0 - initial release
// ============================================================================
module bsub_block
    import bsub_pkg::*;
(
    input  logic [BLK_W-1:0] a,
    input  logic [BLK_W-1:0] b,
    input  logic             bin,
    output logic [BLK_W-1:0] d,
    output logic             bout,
    output logic             skip
);

    logic [BLK_W:0] bw;

    always_comb begin
        bw[0] = bin;
        for (int i = 0; i < BLK_W; i++) begin
            d[i]     = a[i] ^ b[i] ^ bw[i];
            bw[i+1]  = (~a[i] & b[i]) | (~a[i] & bw[i]) | (b[i] & bw[i]);
        end
        // When every bit pair matches, the borrow simply passes through the block.
        skip = &(~(a ^ b));
        bout = skip ? bin : bw[BLK_W];
    end

endmodule
`default_nettype wire

// File: rtl/bsub_skip_serial.sv
`default_nettype none
// ============================================================================
// Module   : bsub_skip_serial
// Purpose  : Block-serial WIDTH-bit subtractor, one 4-bit borrow-skip block per
//            clock, valid/ready on both sides. Optional macro BSUB_SKIP_CNT_EN
//            adds a skip_cnt output counting skip-path blocks.
// Revision : 1.0 - initial release
// ============================================================================
module bsub_skip_serial
    import bsub_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int NBLK  = WIDTH / BLK_W,
    localparam int IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1,
    localparam int CNT_W = $clog2(NBLK + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf,
    output logic             zero
`ifdef BSUB_SKIP_CNT_EN
    ,
    output logic [CNT_W-1:0] skip_cnt
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBLK - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bw_q, bw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [BLK_W-1:0] blk_a, blk_b, blk_d;
    logic             blk_bout, blk_skip;

    assign blk_a = a_q[idx_q*BLK_W +: BLK_W];
    assign blk_b = b_q[idx_q*BLK_W +: BLK_W];

    bsub_block u_blk (
        .a    (blk_a),
        .b    (blk_b),
        .bin  (bw_q),
        .d    (blk_d),
        .bout (blk_bout),
        .skip (blk_skip)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        bw_d    = bw_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = b;
                    bw_d    = borrow_in;
                    diff_d  = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[idx_q*BLK_W +: BLK_W] = blk_d;
                bw_d  = blk_bout;
                cnt_d = cnt_q + CNT_W'(blk_skip);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            bw_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            bw_q    <= bw_d;
            cnt_q   <= cnt_d;
        end
    end

    // Flags are only meaningful on a finished result, so gate them with DONE.
    assign in_ready   = (state_q == IDLE) && rst_n;
    assign out_valid  = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = out_valid && bw_q;
    assign ovf        = out_valid && (a_q[WIDTH-1] != b_q[WIDTH-1])
                                  && (diff_q[WIDTH-1] != a_q[WIDTH-1]);
    assign zero       = out_valid && (diff_q == '0);

`ifdef BSUB_SKIP_CNT_EN
    assign skip_cnt = cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsub_skip_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsub_skip_serial
// Purpose  : Directed self-checking bench for bsub_skip_serial (WIDTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsub_skip_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        borrow_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow_out;
    logic        ovf;
    logic        zero;
`ifdef BSUB_SKIP_CNT_EN
    logic [2:0]  skip_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int lat;

    always #5 clk = ~clk;

    bsub_skip_serial #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf),
        .zero       (zero)
`ifdef BSUB_SKIP_CNT_EN
        ,
        .skip_cnt   (skip_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands, accept them, and count edges until out_valid.
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                            output int l);
        @(negedge clk);
        a = ta; b = tb_; borrow_in = tbin; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 16'hxxxx; b = 16'hxxxx;
        l = 0;
        while (!out_valid && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic check_result(input string n, input int l, input logic [15:0] ed,
                                input logic eb, input logic eo, input logic ez, input int esk);
        check({n, ".latency"}, l, 4);
        check({n, ".out_valid"}, out_valid, 1);
        check({n, ".diff"}, diff, ed);
        check({n, ".borrow_out"}, borrow_out, eb);
        check({n, ".ovf"}, ovf, eo);
        check({n, ".zero"}, zero, ez);
        check({n, ".in_ready"}, in_ready, 0);
`ifdef BSUB_SKIP_CNT_EN
        check({n, ".skip_cnt"}, skip_cnt, esk);
`else
        if (esk < 0) $display("note: negative skip expectation");
`endif
    endtask

    task automatic finish_op(input string n);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({n, ".ovalid_after_hs"}, out_valid, 0);
        check({n, ".in_ready_after_hs"}, in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; borrow_in = 1'b0;
        #12;
        check("rst.out_valid", out_valid, 0);
        check("rst.diff", diff, 0);
        check("rst.borrow_out", borrow_out, 0);
        check("rst.ovf", ovf, 0);
        check("rst.zero", zero, 0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        check("rst.in_ready", in_ready, 1);

        start_op(16'h1234, 16'h0034, 1'b0, lat);
        check_result("t1", lat, 16'h1200, 0, 0, 0, 2);
        finish_op("t1");

        start_op(16'h0000, 16'h0001, 1'b0, lat);
        check_result("t2", lat, 16'hFFFF, 1, 0, 0, 3);
        finish_op("t2");

        start_op(16'h8000, 16'h0001, 1'b0, lat);
        check_result("t3", lat, 16'h7FFF, 0, 1, 0, 2);
        finish_op("t3");

        start_op(16'h7FFF, 16'hFFFF, 1'b0, lat);
        check_result("t4", lat, 16'h8000, 1, 1, 0, 3);
        finish_op("t4");

        start_op(16'hABCD, 16'hABCD, 1'b1, lat);
        check_result("t5", lat, 16'hFFFF, 1, 0, 0, 4);
        finish_op("t5");

        start_op(16'hABCD, 16'hABCD, 1'b0, lat);
        check_result("t6", lat, 16'h0000, 0, 0, 1, 4);
        finish_op("t6");

        // Backpressure: result must hold while out_ready stays low; new operands ignored.
        start_op(16'h1234, 16'h0034, 1'b0, lat);
        check_result("bp", lat, 16'h1200, 0, 0, 0, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; borrow_in = 1'b1;
            @(posedge clk); #1;
            check("bp.hold_valid", out_valid, 1);
            check("bp.hold_diff", diff, 16'h1200);
            check("bp.hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        finish_op("bp");
        start_op(16'h5000, 16'h1000, 1'b0, lat);
        check_result("b2b", lat, 16'h4000, 0, 0, 0, 3);
        finish_op("b2b");

        // Reset while block k=2 is pending; low diff nibbles are already written.
        @(negedge clk);
        a = 16'hFFFF; b = 16'h1111; borrow_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid.partial_diff", diff, 16'h00EE);
        rst_n = 1'b0;
        #1;
        check("mid.out_valid", out_valid, 0);
        check("mid.diff", diff, 0);
        check("mid.borrow_out", borrow_out, 0);
        check("mid.ovf", ovf, 0);
        check("mid.zero", zero, 0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        check("mid.in_ready", in_ready, 1);
        start_op(16'h0100, 16'h0001, 1'b0, lat);
        check_result("post", lat, 16'h00FF, 0, 0, 0, 2);
        finish_op("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
